// File: rtl/gcd_pkg.sv
// Shared definitions for the parametrised GCD unit: FSM states, algorithm
// selectors and the step-select encoding used by the combinational step.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ALG_EUCLID = 0;
    localparam int ALG_STEIN  = 1;

    typedef enum logic [3:0] {
        STEP_TERM_A   = 4'd0,
        STEP_TERM_B   = 4'd1,
        STEP_SWAP     = 4'd2,
        STEP_SUB      = 4'd3,
        STEP_HALVE_AB = 4'd4,
        STEP_HALVE_A  = 4'd5,
        STEP_HALVE_B  = 4'd6,
        STEP_SUBH_A   = 4'd7,
        STEP_SUBH_B   = 4'd8
    } step_sel_t;

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration: picks the step for the configured algorithm
// and produces the next {A,B,K}, the termination flag and the shifted result.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int W   = 16,
    parameter int ALG = ALG_STEIN,
    parameter int KW  = $clog2(W) + 1
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [KW-1:0] k,
    output logic [W-1:0]  a_nxt,
    output logic [W-1:0]  b_nxt,
    output logic [KW-1:0] k_nxt,
    output logic          term,
    output logic [W-1:0]  res
);

    step_sel_t sel;

    generate
        if (ALG == ALG_EUCLID) begin : g_euclid
            always_comb begin
                sel = STEP_TERM_A;
                if (a < b)
                    sel = STEP_SWAP;
                else if (b != '0)
                    sel = STEP_SUB;
            end
        end else begin : g_stein
            // Priority order matters: zero checks first, then common factors of two.
            always_comb begin
                sel = STEP_TERM_A;
                if (a == '0)
                    sel = STEP_TERM_B;
                else if (b == '0)
                    sel = STEP_TERM_A;
                else if (!a[0] && !b[0])
                    sel = STEP_HALVE_AB;
                else if (!a[0])
                    sel = STEP_HALVE_A;
                else if (!b[0])
                    sel = STEP_HALVE_B;
                else if (a >= b)
                    sel = STEP_SUBH_A;
                else
                    sel = STEP_SUBH_B;
            end
        end
    endgenerate

    always_comb begin
        a_nxt = a;
        b_nxt = b;
        k_nxt = k;
        term  = 1'b0;
        res   = ((sel == STEP_TERM_B) ? b : a) << k;
        case (sel)
            STEP_TERM_A, STEP_TERM_B: term = 1'b1;
            STEP_SWAP: begin
                a_nxt = b;
                b_nxt = a;
            end
            STEP_SUB:      a_nxt = a - b;
            STEP_HALVE_AB: begin
                a_nxt = a >> 1;
                b_nxt = b >> 1;
                k_nxt = k + 1'b1;
            end
            STEP_HALVE_A:  a_nxt = a >> 1;
            STEP_HALVE_B:  b_nxt = b >> 1;
            STEP_SUBH_A:   a_nxt = (a - b) >> 1;
            STEP_SUBH_B:   b_nxt = (b - a) >> 1;
            default:       term = 1'b0;
        endcase
    end

endmodule

// File: rtl/gcd_unit_param.sv
// Parametrised GCD unit (Euclid or Stein) with valid/ready on both sides.
// Define GCD_CYCLE_CNT_EN to add the result_cycles port and CALC-cycle counter.
module gcd_unit_param
    import gcd_pkg::*;
#(
    parameter int W   = 16,
    parameter int ALG = ALG_STEIN,
    parameter int CW  = $clog2(2*W+2)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [W-1:0]  operand_A,
    input  logic [W-1:0]  operand_B,
    input  logic          input_available,
    output logic          input_rdy,
    output logic [W-1:0]  result_data,
    output logic          result_rdy,
    input  logic          result_taken
`ifdef GCD_CYCLE_CNT_EN
    ,
    output logic [CW-1:0] result_cycles
`endif
);

    localparam int KW = $clog2(W) + 1;

    state_t        state, state_nxt;
    logic [W-1:0]  a_q, b_q, a_nxt, b_nxt, step_res;
    logic [KW-1:0] k_q, k_nxt;
    logic          step_term;
    logic          accept, take;

    assign accept = input_available & input_rdy;
    assign take   = result_rdy & result_taken;

    gcd_step #(.W(W), .ALG(ALG), .KW(KW)) u_step (
        .a     (a_q),
        .b     (b_q),
        .k     (k_q),
        .a_nxt (a_nxt),
        .b_nxt (b_nxt),
        .k_nxt (k_nxt),
        .term  (step_term),
        .res   (step_res)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = CALC;
            CALC:    if (step_term) state_nxt = DONE;
            DONE:    if (take)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        input_rdy  = (state == IDLE);
        result_rdy = (state == DONE);
    end

    // The result register is zero outside DONE so a stale gcd never leaks out.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            result_data <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_q <= operand_A;
                    b_q <= operand_B;
                    k_q <= '0;
                end
                CALC: begin
                    a_q <= a_nxt;
                    b_q <= b_nxt;
                    k_q <= k_nxt;
                    if (step_term)
                        result_data <= step_res;
                end
                DONE: if (take) result_data <= '0;
                default: result_data <= '0;
            endcase
        end
    end

`ifdef GCD_CYCLE_CNT_EN
    // Counts every CALC cycle including the terminating one, then freezes.
    always_ff @(posedge clock) begin
        if (reset)
            result_cycles <= '0;
        else if (accept)
            result_cycles <= '0;
        else if (state == CALC && result_cycles != {CW{1'b1}})
            result_cycles <= result_cycles + 1'b1;
    end
`endif

endmodule

// File: tb/tb_gcd_unit_param.sv
// Self-checking bench for gcd_unit_param: a Stein and a Euclid instance share
// operands; a modulo-based reference model plus directed literal checks.
module tb_gcd_unit_param;

    localparam int W  = 16;
    localparam int CW = $clog2(2*W+2);

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic         avail_s = 1'b0, avail_e = 1'b0, taken = 1'b0;
    logic [W-1:0] res_s, res_e;
    logic         irdy_s, irdy_e, rrdy_s, rrdy_e;
`ifdef GCD_CYCLE_CNT_EN
    logic [CW-1:0] cyc_s, cyc_e;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    gcd_unit_param #(.W(W), .ALG(1)) u_stein (
        .clock           (clock),
        .reset           (reset),
        .operand_A       (op_a),
        .operand_B       (op_b),
        .input_available (avail_s),
        .input_rdy       (irdy_s),
        .result_data     (res_s),
        .result_rdy      (rrdy_s),
        .result_taken    (taken)
`ifdef GCD_CYCLE_CNT_EN
        ,
        .result_cycles   (cyc_s)
`endif
    );

    gcd_unit_param #(.W(W), .ALG(0)) u_euclid (
        .clock           (clock),
        .reset           (reset),
        .operand_A       (op_a),
        .operand_B       (op_b),
        .input_available (avail_e),
        .input_rdy       (irdy_e),
        .result_data     (res_e),
        .result_rdy      (rrdy_e),
        .result_taken    (taken)
`ifdef GCD_CYCLE_CNT_EN
        ,
        .result_cycles   (cyc_e)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Transaction-level model: which instance holds an operation and its expected gcd.
    logic         pend_s = 1'b0, pend_e = 1'b0;
    logic [W-1:0] exp_s = '0, exp_e = '0;

    always @(posedge clock) begin
        if (reset) begin
            pend_s <= 1'b0;
            pend_e <= 1'b0;
        end else begin
            if (!pend_s && avail_s) begin
                pend_s <= 1'b1;
                exp_s  <= ref_gcd(op_a, op_b);
            end else if (pend_s && rrdy_s && taken)
                pend_s <= 1'b0;
            if (!pend_e && avail_e) begin
                pend_e <= 1'b1;
                exp_e  <= ref_gcd(op_a, op_b);
            end else if (pend_e && rrdy_e && taken)
                pend_e <= 1'b0;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            checkOutput("model_in_rdy_stein", irdy_s, !pend_s);
            checkOutput("model_in_rdy_euclid", irdy_e, !pend_e);
            checkOutput("model_res_stein", res_s, rrdy_s ? exp_s : '0);
            checkOutput("model_res_euclid", res_e, rrdy_e ? exp_e : '0);
            checkOutput("model_rdy_idle_stein", rrdy_s & !pend_s, 0);
            checkOutput("model_rdy_idle_euclid", rrdy_e & !pend_e, 0);
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input bit e);
        op_a    = a;
        op_b    = b;
        avail_s = s;
        avail_e = e;
        @(negedge clock);
        avail_s = 1'b0;
        avail_e = 1'b0;
    endtask

    task automatic waitResult(input bit s, input bit e, input int budget, output int lat_s);
        int n;
        n     = 0;
        lat_s = -1;
        while (n <= budget) begin
            if (s && rrdy_s && lat_s < 0)
                lat_s = n;
            if ((!s || rrdy_s) && (!e || rrdy_e))
                break;
            @(negedge clock);
            n++;
        end
        checkOutput("wait_result_in_budget", ((!s || rrdy_s) && (!e || rrdy_e)), 1);
    endtask

    task automatic takeResult();
        taken = 1'b1;
        @(negedge clock);
        taken = 1'b0;
        checkOutput("take_in_rdy_stein", irdy_s, 1);
        checkOutput("take_in_rdy_euclid", irdy_e, 1);
        checkOutput("take_rdy_low_stein", rrdy_s, 0);
    endtask

    logic [W-1:0] vec_a [4] = '{16'd48, 16'd0, 16'd9, 16'd0};
    logic [W-1:0] vec_b [4] = '{16'd18, 16'd9, 16'd0, 16'd0};
    logic [W-1:0] vec_g [4] = '{16'd6, 16'd9, 16'd9, 16'd0};

    initial begin
        int lat;
        logic [W-1:0] ra, rb;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        checkOutput("reset_in_rdy", irdy_s, 1);
        checkOutput("reset_res_rdy", rrdy_s, 0);
        checkOutput("reset_res_data", res_s, 0);
`ifdef GCD_CYCLE_CNT_EN
        checkOutput("reset_cycles", cyc_s, 0);
`endif

        applyStimulus(16'd27, 16'd15, 1, 0);
        waitResult(1, 0, 40, lat);
        checkOutput("t1_result", res_s, 3);
        checkOutput("t1_latency_le_33", (lat >= 0 && lat <= 33), 1);
        takeResult();

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vec_a[i], vec_b[i], 1, 1);
            waitResult(1, 1, 200, lat);
            checkOutput($sformatf("t2_stein_%0d", i), res_s, vec_g[i]);
            checkOutput($sformatf("t2_euclid_%0d", i), res_e, vec_g[i]);
            takeResult();
        end

        applyStimulus(16'hFFFF, 16'hFFFF, 1, 1);
        waitResult(1, 1, 100, lat);
        checkOutput("t3_max_stein", res_s, 65535);
        checkOutput("t3_max_euclid", res_e, 65535);
        takeResult();
        applyStimulus(16'hFFFF, 16'd1, 1, 0);
        waitResult(1, 0, 40, lat);
        checkOutput("t3_max_one_stein", res_s, 1);
        checkOutput("t3_latency_le_33", (lat >= 0 && lat <= 33), 1);
        takeResult();

        applyStimulus(16'd100, 16'd75, 1, 1);
        waitResult(1, 1, 200, lat);
        op_a    = 16'd7;
        op_b    = 16'd5;
        avail_s = 1'b1;
        avail_e = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            checkOutput("t4_hold_stein", res_s, 25);
            checkOutput("t4_hold_euclid", res_e, 25);
            checkOutput("t4_busy_in_rdy", irdy_s | irdy_e, 0);
        end
        avail_s = 1'b0;
        avail_e = 1'b0;
        takeResult();

        applyStimulus(16'd1024, 16'd768, 1, 1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("t5_reset_in_rdy", irdy_s & irdy_e, 1);
        checkOutput("t5_reset_res_rdy", rrdy_s | rrdy_e, 0);
        applyStimulus(16'd12, 16'd8, 1, 1);
        waitResult(1, 1, 100, lat);
        checkOutput("t5_new_stein", res_s, 4);
        checkOutput("t5_new_euclid", res_e, 4);
        takeResult();

`ifdef GCD_CYCLE_CNT_EN
        applyStimulus(16'd64, 16'd64, 1, 0);
        waitResult(1, 0, 40, lat);
        checkOutput("t6_result", res_s, 64);
        checkOutput("t6_cycles", cyc_s, 8);
        takeResult();
        checkOutput("t6_cycles_held", cyc_s, 8);
`endif

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(1000, 0));
            rb = W'($urandom_range(1000, 0));
            applyStimulus(ra, rb, 1, 1);
            waitResult(1, 1, 4000, lat);
            takeResult();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
